// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: drives the IM address, redirects on EX-stage flow changes,
// honours ID hazard stalls and halt, and pipelines the fetched PC into IM_ID and ID_EX.
module pc_fetch_ctrl #(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_IM_ID,
    input  logic            flow_change_ID_EX,
    input  logic [PC_W-1:0] tgt_ID_EX,
    input  logic            hlt_ID_EX,
    output logic [PC_W-1:0] iaddr,
    output logic            instr_vld_IM_ID,
    output logic [PC_W-1:0] pc_IM_ID,
    output logic [PC_W-1:0] pc_ID_EX,
    output logic            flush_ID_EX,
    output logic            halted
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REDIR = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign iaddr  = pc;

    // Priority inside RUN: flow change beats halt, halt beats stall, stall beats advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= RUN;
            pc              <= RESET_VEC;
            pc_IM_ID        <= '0;
            pc_ID_EX        <= '0;
            instr_vld_IM_ID <= 1'b0;
            halted          <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (flow_change_ID_EX) begin
                        pc              <= tgt_ID_EX;
                        pc_IM_ID        <= pc;
                        pc_ID_EX        <= pc_IM_ID;
                        instr_vld_IM_ID <= 1'b0;
                        state           <= REDIR;
                    end else if (hlt_ID_EX) begin
                        instr_vld_IM_ID <= 1'b0;
                        halted          <= 1'b1;
                        state           <= HALT;
                    end else if (!stall_IM_ID) begin
                        pc              <= pc_inc;
                        pc_IM_ID        <= pc;
                        pc_ID_EX        <= pc_IM_ID;
                        instr_vld_IM_ID <= 1'b1;
                    end
                end
                // The EX slot holds a bubble here, so every input is ignored.
                REDIR: begin
                    pc              <= pc_inc;
                    pc_IM_ID        <= pc;
                    instr_vld_IM_ID <= 1'b1;
                    state           <= RUN;
                end
                HALT: begin
                    instr_vld_IM_ID <= 1'b0;
                    halted          <= 1'b1;
                end
                default: begin
                    instr_vld_IM_ID <= 1'b0;
                    state           <= RUN;
                end
            endcase
        end
    end

    always_comb begin
        flush_ID_EX = 1'b1;
        if (state == RUN) begin
            flush_ID_EX = flow_change_ID_EX | hlt_ID_EX | stall_IM_ID;
        end
    end

endmodule
